hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and multiply/divide scheduling controller for the 5-stage MIPS pipeline. It watches the instruction words held in the D/E/M/W pipeline registers and drives their `stall` and bubble controls. It also drives the operand-forwarding selects for the D-stage branch comparator and the E-stage ALU inputs. A cycle counter tracks the occupancy of the multi-cycle HI/LO unit, and a saturating counter accumulates stall cycles for performance analysis.

## Interface
Parameters:
- `MULT_LAT`, default 5: busy cycles after mult/multu leaves E.
- `DIV_LAT`, default 10: busy cycles after div/divu leaves E.
- `CNT_W`, default 4: busy-counter width. Requires `DIV_LAT`, `MULT_LAT` < 2^`CNT_W`.

Ports:
- `Clk` in 1: clock, rising edge.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `InstrD`, `InstrE`, `InstrM`, `InstrW` in 32 each: stage instruction words. 0 denotes a bubble.
- `regWriteE`, `regWriteM`, `regWriteW` in 1 each: stage writes the register file.
- `stallF` out 1: hold PC.
- `stallD` out 1: hold the D register.
- `stallE` out 1: bubble the E register (its stall/Clr input).
- `fwdRsD`, `fwdRtD` out 2 each: branch-compare operand select.
- `fwdRsE`, `fwdRtE` out 2 each: ALU operand select.
- `mdBusy` out 1: HI/LO unit busy.
- `stallCnt` out 32: saturating stall-cycle count.

## Operation
Decode rules:
- op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
- Load: op ∈ {0x20, 0x21, 0x23, 0x24, 0x25}.
- Branch/jr in D: op ∈ {0x04, 0x05}, or op=0 with funct=0x08.
- MD start: op=0 with funct ∈ {0x18, 0x19, 0x1A, 0x1B}.
- MD use: op=0 with funct ∈ {0x10, 0x11, 0x12, 0x13}, or any MD start.

Destination register `dst(X)`:
- 0 if `regWriteX`=0.
- Otherwise rd when op=0, 31 when op=0x03 (jal), else rt.

Source registers:
- rs and rt of D and E are always treated as read.
- A destination of 0 never matches, so it never forwards or stalls.

Stall conditions; `stall` is the OR of:
- Load-use: E is a load and dst(E) ∈ {rsD, rtD}.
- Branch-ALU: D is branch/jr and dst(E) ∈ {rsD, rtD}.
- Branch-load: D is branch/jr, M is a load, and dst(M) ∈ {rsD, rtD}.
- MD: D is MD use and (`mdBusy`, or E is MD start).

Stall outputs: `stallF` = `stallD` = `stallE` = `stall`.

Forwarding, E stage (per operand rsE/rtE):
- 01 if dst(M) matches.
- Else 10 if dst(W) matches.
- Else 00.
- M has priority over W.

Forwarding, D stage (per operand rsD/rtD):
- 01 if dst(M) matches and M is not a load.
- Else 10 if dst(W) matches.
- Else 00.

Busy counter `cnt` (registered, CNT_W bits):
- E is mult/multu: load `MULT_LAT`.
- E is div/divu: load `DIV_LAT`.
- Else if `cnt`≠0: decrement by 1.
- A load always overrides a decrement (newest start wins).
- `mdBusy` = (`cnt`≠0).

`stallCnt`: +1 on every edge where `stall`=1, saturating at 0xFFFFFFFF.

## Timing
- `stall`, all `fwd*`, and `mdBusy` are combinational from the inputs and `cnt`. There are no registered outputs other than `cnt`-derived `mdBusy` and `stallCnt`.
- Reset (`Rst_n`=0): `cnt`=0 and `stallCnt`=0 immediately. `mdBusy`=0. The remaining outputs follow their decode of the inputs.
- Reset asserted mid-count aborts the count. No stall is carried across reset.
- A stall inserts a bubble (`InstrE`=0 on the next edge), and D re-evaluates the following cycle.
- Load-use costs 1 stall cycle.
- Branch after an ALU producer costs 1 cycle.
- Branch directly after a load costs 2 cycles.
- MD use immediately behind an MD start stalls 1+`MULT_LAT` cycles (mult) or 1+`DIV_LAT` cycles (div).
- MD use behind an E-stage MD start while `cnt`≠0 still stalls; `cnt` is reloaded.

## Test plan
- lw $8 in E, addu $9,$8,$10 in D -> `stall`=1 for exactly 1 cycle. Two cycles later, addu in E with lw in W -> `fwdRsE`=10.
- addu $3 in M and addiu $3 in W, subu $5,$3,$3 in E -> `fwdRsE`=`fwdRtE`=01. Remove M's write -> both 10.
- addu $4 in E, beq $4,$0 in D -> 1 stall cycle, then `fwdRsD`=01. Repeat with lw $4 -> 2 stall cycles, then `fwdRsD`=10.
- mult in E, mflo in D (`MULT_LAT`=5) -> `stall` high for 6 consecutive cycles, `mdBusy` high for cycles 2-6. div -> 11 cycles. `stallCnt` increases by 6, then by 11.
- Writer with dst $0 (addu $0,...) in E/M/W, and D/E reading $0 -> `stall`=0, all `fwd*`=00.
- `Rst_n` pulsed low while `cnt`=7 after div -> `mdBusy`=0 and `stallCnt`=0 without a clock edge. A following mflo in D does not stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection, operand forwarding and HI/LO occupancy
// tracking for a 5-stage MIPS pipeline. Stall and forward decisions are
// combinational from the stage instruction words; only the HI/LO busy counter
// and the stall-cycle statistics counter hold state.

module hazard_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    // Both latencies must fit in CNT_W bits.
    parameter int unsigned CNT_W    = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] InstrD,
    input  logic [31:0] InstrE,
    input  logic [31:0] InstrM,
    input  logic [31:0] InstrW,
    input  logic        regWriteE,
    input  logic        regWriteM,
    input  logic        regWriteW,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic [1:0]  fwdRsD,
    output logic [1:0]  fwdRtD,
    output logic [1:0]  fwdRsE,
    output logic [1:0]  fwdRtE,
    output logic        mdBusy,
    output logic [31:0] stallCnt
);

    // ------------------------------------------------------------------
    // Opcode / function encodings
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    localparam logic [4:0] REG_RA     = 5'd31;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

    // Operand source select shared by the D-stage comparator and E-stage ALU.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,   // register file / pipeline register value
        FWD_M  = 2'b01,   // result held in the M stage
        FWD_W  = 2'b10    // result held in the W stage
    } fwd_sel_e;

    // ------------------------------------------------------------------
    // Instruction decode helpers
    // ------------------------------------------------------------------
    function automatic logic is_load(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_branch(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        return (op == OP_BEQ) || (op == OP_BNE) ||
               ((op == OP_SPECIAL) && (instr[5:0] == FN_JR));
    endfunction

    function automatic logic is_mult(input logic [31:0] instr);
        return (instr[31:26] == OP_SPECIAL) &&
               ((instr[5:0] == FN_MULT) || (instr[5:0] == FN_MULTU));
    endfunction

    function automatic logic is_div(input logic [31:0] instr);
        return (instr[31:26] == OP_SPECIAL) &&
               ((instr[5:0] == FN_DIV) || (instr[5:0] == FN_DIVU));
    endfunction

    // Anything that reads or writes HI/LO, including a new mult/div.
    function automatic logic is_md_use(input logic [31:0] instr);
        logic hilo_move;
        hilo_move = (instr[31:26] == OP_SPECIAL) &&
                    ((instr[5:0] == FN_MFHI) || (instr[5:0] == FN_MTHI) ||
                     (instr[5:0] == FN_MFLO) || (instr[5:0] == FN_MTLO));
        return hilo_move || is_mult(instr) || is_div(instr);
    endfunction

    // Register actually written by a stage; 0 means "writes nothing that
    // can ever be forwarded or cause a hazard".
    function automatic logic [4:0] dst_of(input logic [31:0] instr,
                                          input logic        we);
        if (!we)                           return 5'd0;
        else if (instr[31:26] == OP_SPECIAL) return instr[15:11];
        else if (instr[31:26] == OP_JAL)     return REG_RA;
        else                                 return instr[20:16];
    endfunction

    // $0 is hard-wired, so a zero destination never matches a source.
    function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // ------------------------------------------------------------------
    // Per-stage decode
    // ------------------------------------------------------------------
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] dst_e, dst_m, dst_w;
    logic       load_e, load_m;
    logic       branch_d, md_use_d;
    logic       mult_e, div_e, md_start_e;

    assign rs_d       = InstrD[25:21];
    assign rt_d       = InstrD[20:16];
    assign rs_e       = InstrE[25:21];
    assign rt_e       = InstrE[20:16];

    assign dst_e      = dst_of(InstrE, regWriteE);
    assign dst_m      = dst_of(InstrM, regWriteM);
    assign dst_w      = dst_of(InstrW, regWriteW);

    assign load_e     = is_load(InstrE);
    assign load_m     = is_load(InstrM);
    assign branch_d   = is_branch(InstrD);
    assign md_use_d   = is_md_use(InstrD);
    assign mult_e     = is_mult(InstrE);
    assign div_e      = is_div(InstrE);
    assign md_start_e = mult_e || div_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic             md_busy;

    assign md_busy = (cnt_q != '0);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic stall;
    logic load_use, branch_alu, branch_load, md_hazard;

    // Combine the four hazard sources into the single pipeline stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        load_use    = 1'b0;
        branch_alu  = 1'b0;
        branch_load = 1'b0;
        md_hazard   = 1'b0;

        if (load_e && (hit(dst_e, rs_d) || hit(dst_e, rt_d)))
            load_use = 1'b1;

        // The branch comparator sits in D, so even an ALU result in E is
        // one cycle too late for it.
        if (branch_d && (hit(dst_e, rs_d) || hit(dst_e, rt_d)))
            branch_alu = 1'b1;

        // Load data only exists at the end of M; a branch must wait until
        // the load reaches W.
        if (branch_d && load_m && (hit(dst_m, rs_d) || hit(dst_m, rt_d)))
            branch_load = 1'b1;

        // HI/LO readers wait while the unit is busy or about to start.
        if (md_use_d && (md_busy || md_start_e))
            md_hazard = 1'b1;

        stall = load_use || branch_alu || branch_load || md_hazard;
    end

    assign stallF = stall;
    assign stallD = stall;
    assign stallE = stall;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    fwd_sel_e fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    // E-stage ALU operands: nearest producer (M) wins over older (W).
    always_comb begin
        fwd_rs_e = FWD_RF;
        fwd_rt_e = FWD_RF;

        if (hit(dst_m, rs_e))      fwd_rs_e = FWD_M;
        else if (hit(dst_w, rs_e)) fwd_rs_e = FWD_W;

        if (hit(dst_m, rt_e))      fwd_rt_e = FWD_M;
        else if (hit(dst_w, rt_e)) fwd_rt_e = FWD_W;
    end

    // D-stage comparator operands: a load in M has no data yet, so it is
    // never a forwarding source here (the branch-load stall covers it).
    always_comb begin
        fwd_rs_d = FWD_RF;
        fwd_rt_d = FWD_RF;

        if (!load_m && hit(dst_m, rs_d)) fwd_rs_d = FWD_M;
        else if (hit(dst_w, rs_d))       fwd_rs_d = FWD_W;

        if (!load_m && hit(dst_m, rt_d)) fwd_rt_d = FWD_M;
        else if (hit(dst_w, rt_d))       fwd_rt_d = FWD_W;
    end

    assign fwdRsD = fwd_rs_d;
    assign fwdRtD = fwd_rt_d;
    assign fwdRsE = fwd_rs_e;
    assign fwdRtE = fwd_rt_e;

    // ------------------------------------------------------------------
    // HI/LO busy counter
    // ------------------------------------------------------------------
    // Reload on a new mult/div in E (newest start wins), else count down.
    always_comb begin
        cnt_d = cnt_q;
        if (mult_e)              cnt_d = MULT_LOAD;
        else if (div_e)          cnt_d = DIV_LOAD;
        else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // State registers; reset aborts any HI/LO count in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mdBusy   = md_busy;
    assign stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of single-cycle decode
// vectors followed by hand-written multi-cycle sequences (load-use, branch
// stalls, mult/div occupancy, reset mid-count). Expected records are queued
// when stimulus is driven and popped when outputs are sampled.

module tb_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] InstrD, InstrE, InstrM, InstrW;
    logic        regWriteE, regWriteM, regWriteW;
    logic        stallF, stallD, stallE;
    logic [1:0]  fwdRsD, fwdRtD, fwdRsE, fwdRtE;
    logic        mdBusy;
    logic [31:0] stallCnt;

    hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .InstrD    (InstrD),
        .InstrE    (InstrE),
        .InstrM    (InstrM),
        .InstrW    (InstrW),
        .regWriteE (regWriteE),
        .regWriteM (regWriteM),
        .regWriteW (regWriteW),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .fwdRsD    (fwdRsD),
        .fwdRtD    (fwdRtD),
        .fwdRsE    (fwdRsE),
        .fwdRtE    (fwdRtE),
        .mdBusy    (mdBusy),
        .stallCnt  (stallCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [31:0] d, e, m, w;
        logic        we_e, we_m, we_w;
        logic        stall;
        logic [1:0]  frsd, frtd, frse, frte;
        logic        busy;
    } vec_t;

    vec_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_sc   = 32'd0;   // expected stallCnt

    localparam int ADDU = 'h21, SUBU = 'h23, JR = 'h08;
    localparam int MULT = 'h18, DIV  = 'h1A, MFLO = 'h12, MFHI = 'h10;
    localparam int OP_LW = 'h23, OP_LB = 'h20, OP_LHU = 'h25;
    localparam int OP_BEQ = 'h04, OP_BNE = 'h05, OP_ADDIU = 'h09;

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic vec_t mk(string n, logic [31:0] d, logic [31:0] e,
                                logic [31:0] m, logic [31:0] w,
                                logic we_e, logic we_m, logic we_w,
                                logic st, logic [1:0] frsd, logic [1:0] frtd,
                                logic [1:0] frse, logic [1:0] frte, logic busy);
        vec_t v;
        v.name = n; v.d = d; v.e = e; v.m = m; v.w = w;
        v.we_e = we_e; v.we_m = we_m; v.we_w = we_w;
        v.stall = st; v.frsd = frsd; v.frtd = frtd;
        v.frse = frse; v.frte = frte; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, sample on the falling edge, then step
    // to just after the next rising edge.
    task automatic apply(input vec_t v);
        vec_t x;
        InstrD = v.d; InstrE = v.e; InstrM = v.m; InstrW = v.w;
        regWriteE = v.we_e; regWriteM = v.we_m; regWriteW = v.we_w;
        exp_q.push_back(v);
        @(negedge Clk);
        x = exp_q.pop_front();
        check({x.name, ".stallF"}, 32'(stallF), 32'(x.stall));
        check({x.name, ".stallD"}, 32'(stallD), 32'(x.stall));
        check({x.name, ".stallE"}, 32'(stallE), 32'(x.stall));
        check({x.name, ".fwdRsD"}, 32'(fwdRsD), 32'(x.frsd));
        check({x.name, ".fwdRtD"}, 32'(fwdRtD), 32'(x.frtd));
        check({x.name, ".fwdRsE"}, 32'(fwdRsE), 32'(x.frse));
        check({x.name, ".fwdRtE"}, 32'(fwdRtE), 32'(x.frte));
        check({x.name, ".mdBusy"}, 32'(mdBusy), 32'(x.busy));
        if (x.stall) exp_sc = exp_sc + 32'd1;
        @(posedge Clk);
        #1;
    endtask

    // Hard time limit in case the bench ever loses step with the clock.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[16];
        logic [31:0] mflo_i, mult_i, div_i, jal_i;

        mflo_i = rtype(0, 0, 8, MFLO);
        mult_i = rtype(1, 2, 0, MULT);
        div_i  = rtype(1, 2, 0, DIV);
        jal_i  = {6'h03, 26'h0000100};

        //            name          D                       E                        M                              W                      wE wM wW st rsD rtD rsE rtE busy
        tbl[0]  = mk("load_use",   rtype(8,10,9,ADDU),     itype(OP_LW,29,8,0),     0,                             0,                     1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk("fwdE_M",     0,                      rtype(3,3,5,SUBU),       rtype(1,2,3,ADDU),             itype(OP_ADDIU,1,3,5), 0, 1, 1, 0, 0, 0, 1, 1, 0);
        tbl[2]  = mk("fwdE_W",     0,                      rtype(3,3,5,SUBU),       rtype(1,2,3,ADDU),             itype(OP_ADDIU,1,3,5), 0, 0, 1, 0, 0, 0, 2, 2, 0);
        tbl[3]  = mk("zero_dst",   itype(OP_BEQ,0,0,4),    rtype(0,0,0,ADDU),       rtype(1,2,0,ADDU),             rtype(1,2,0,ADDU),     1, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk("br_alu",     itype(OP_BEQ,4,0,8),    rtype(1,2,4,ADDU),       0,                             0,                     1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk("br_loadM",   itype(OP_BEQ,4,5,8),    0,                       itype(OP_LW,29,4,0),           0,                     0, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk("fwdD_M",     itype(OP_BNE,4,5,8),    0,                       rtype(1,2,4,ADDU),             0,                     0, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk("fwdD_W",     itype(OP_BEQ,4,5,8),    0,                       0,                             itype(OP_LW,29,5,0),   0, 0, 1, 0, 0, 2, 0, 0, 0);
        tbl[8]  = mk("jal_jr",     rtype(31,0,0,JR),       rtype(31,0,0,JR),        jal_i,                         0,                     0, 1, 0, 0, 1, 0, 1, 0, 0);
        tbl[9]  = mk("lw_no_we",   rtype(8,10,9,ADDU),     itype(OP_LW,29,8,0),     0,                             0,                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk("jr_alu",     rtype(31,0,0,JR),       itype(OP_ADDIU,0,31,1),  0,                             0,                     1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[11] = mk("fwdE_rtW",   0,                      rtype(2,9,1,ADDU),       0,                             rtype(5,6,9,ADDU),     1, 0, 1, 0, 0, 0, 0, 2, 0);
        tbl[12] = mk("itype_dst",  0,                      rtype(3,7,1,ADDU),       itype(OP_ADDIU,3,7,'h1800),    0,                     1, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[13] = mk("mflo_idle",  mflo_i,                 rtype(1,2,3,ADDU),       0,                             0,                     1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk("lb_use",     rtype(1,6,2,ADDU),      itype(OP_LB,29,6,0),     0,                             0,                     1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[15] = mk("lhu_use",    rtype(6,0,2,ADDU),      itype(OP_LHU,29,6,0),    0,                             0,                     1, 0, 0, 1, 0, 0, 0, 0, 0);

        // Reset state: counters clear asynchronously, decode of zeros is idle.
        Rst_n = 1'b0;
        InstrD = '0; InstrE = '0; InstrM = '0; InstrW = '0;
        regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
        #2;
        check("reset.mdBusy",   32'(mdBusy), 32'd0);
        check("reset.stallCnt", stallCnt,    32'd0);
        check("reset.stallF",   32'(stallF), 32'd0);
        check("reset.fwdRsE",   32'(fwdRsE), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 16; i++) apply(tbl[i]);
        check("table.stallCnt", stallCnt, exp_sc);

        // Load-use: one stall, then W forwards the loaded value to E.
        apply(mk("lu.c0", rtype(8,10,9,ADDU), itype(OP_LW,29,8,0), 0, 0, 1,0,0, 1,0,0,0,0,0));
        apply(mk("lu.c1", rtype(8,10,9,ADDU), 0, itype(OP_LW,29,8,0), 0, 0,1,0, 0,0,0,0,0,0));
        apply(mk("lu.c2", 0, rtype(8,10,9,ADDU), 0, itype(OP_LW,29,8,0), 1,0,1, 0,0,0,2,0,0));
        check("lu.stallCnt", stallCnt, exp_sc);

        // Branch after ALU producer: 1 stall, then forward from M.
        apply(mk("ba.c0", itype(OP_BEQ,4,0,8), rtype(1,2,4,ADDU), 0, 0, 1,0,0, 1,0,0,0,0,0));
        apply(mk("ba.c1", itype(OP_BEQ,4,0,8), 0, rtype(1,2,4,ADDU), 0, 0,1,0, 0,1,0,0,0,0));
        // Branch after load: 2 stalls, then forward from W.
        apply(mk("bl.c0", itype(OP_BEQ,4,0,8), itype(OP_LW,29,4,0), 0, 0, 1,0,0, 1,0,0,0,0,0));
        apply(mk("bl.c1", itype(OP_BEQ,4,0,8), 0, itype(OP_LW,29,4,0), 0, 0,1,0, 1,0,0,0,0,0));
        apply(mk("bl.c2", itype(OP_BEQ,4,0,8), 0, 0, itype(OP_LW,29,4,0), 0,0,1, 0,2,0,0,0,0));
        check("br.stallCnt", stallCnt, exp_sc);

        // mult then mflo: 1 + MULT_LAT stall cycles.
        apply(mk("mult.c0", mflo_i, mult_i, 0, 0, 0,0,0, 1,0,0,0,0,0));
        for (int i = 1; i <= 5; i++)
            apply(mk($sformatf("mult.c%0d", i), mflo_i, 0, 0, 0, 0,0,0, 1,0,0,0,0,1));
        apply(mk("mult.free", mflo_i, 0, 0, 0, 0,0,0, 0,0,0,0,0,0));
        check("mult.stallCnt", stallCnt, exp_sc);

        // div then mflo: 1 + DIV_LAT stall cycles.
        apply(mk("div.c0", mflo_i, div_i, 0, 0, 0,0,0, 1,0,0,0,0,0));
        for (int i = 1; i <= 10; i++)
            apply(mk($sformatf("div.c%0d", i), mflo_i, 0, 0, 0, 0,0,0, 1,0,0,0,0,1));
        apply(mk("div.free", mflo_i, 0, 0, 0, 0,0,0, 0,0,0,0,0,0));
        check("div.stallCnt", stallCnt, exp_sc);

        // div behind a still-busy mult reloads the counter to DIV_LAT.
        apply(mk("rl.c0", 0, mult_i, 0, 0, 0,0,0, 0,0,0,0,0,0));
        apply(mk("rl.c1", mflo_i, div_i, 0, 0, 0,0,0, 1,0,0,0,0,1));
        for (int i = 2; i <= 11; i++)
            apply(mk($sformatf("rl.c%0d", i), mflo_i, 0, 0, 0, 0,0,0, 1,0,0,0,0,1));
        apply(mk("rl.free", mflo_i, 0, 0, 0, 0,0,0, 0,0,0,0,0,0));
        check("rl.stallCnt", stallCnt, exp_sc);

        // Reset while the div counter sits at 7 clears everything at once.
        apply(mk("rst.c0", 0, div_i, 0, 0, 0,0,0, 0,0,0,0,0,0));
        for (int i = 1; i <= 3; i++)
            apply(mk($sformatf("rst.c%0d", i), 0, 0, 0, 0, 0,0,0, 0,0,0,0,0,1));
        check("rst.pre_busy", 32'(mdBusy), 32'd1);
        Rst_n = 1'b0;
        #2;
        check("rst.mdBusy",   32'(mdBusy), 32'd0);
        check("rst.stallCnt", stallCnt,    32'd0);
        exp_sc = 32'd0;
        Rst_n = 1'b1;
        #1;
        apply(mk("rst.mflo", mflo_i, 0, 0, 0, 0,0,0, 0,0,0,0,0,0));
        check("rst.post_stallCnt", stallCnt, exp_sc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
